// File: rtl/enemy_y_tracker_if.sv
// Bundles the enemy tracker control inputs and per-channel status outputs.
// The master side drives control; the slave side is the tracker itself.
interface enemy_y_tracker_if #(
  parameter int N_CH = 10,
  parameter int Y_W  = 8
);
  logic                   move_en;
  logic [1:0]             rate;
  logic [N_CH-1:0]        ch_en;
  logic [N_CH-1:0]        destroyed;
  logic [N_CH-1:0]        spawn;
  logic [Y_W-1:0]         spawn_y;
  logic [2*N_CH-1:0]      step;
  logic [N_CH*Y_W-1:0]    y_flat;
  logic [N_CH-1:0]        active;
  logic [N_CH-1:0]        touch_edge;
  logic                   tick;

  modport master (
    output move_en, rate, ch_en, destroyed, spawn, spawn_y, step,
    input  y_flat, active, touch_edge, tick
  );

  modport slave (
    input  move_en, rate, ch_en, destroyed, spawn, spawn_y, step,
    output y_flat, active, touch_edge, tick
  );
endinterface

// File: rtl/enemy_y_tracker.sv
// Tracks the Y position of N_CH independent enemies falling toward a bottom edge,
// stepped by a shared programmable prescaler tick.
module enemy_y_tracker #(
  parameter int N_CH  = 10,
  parameter int Y_W   = 8,
  parameter int Y_MAX = 110,
  parameter int DIV_W = 24,
  parameter int DIV0  = 12499999,
  parameter int DIV1  = 6499999,
  parameter int DIV2  = 3999999,
  parameter int DIV3  = 1999999
) (
  input  logic                clk,
  input  logic                reset_n,
  enemy_y_tracker_if.slave    bus
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FLY  = 2'd1,
    ST_EDGE = 2'd2
  } ch_state_e;

  localparam logic [Y_W-1:0]   Y_MAX_V = Y_W'(Y_MAX);
  localparam logic [DIV_W-1:0] DIV0_V  = DIV_W'(DIV0);
  localparam logic [DIV_W-1:0] DIV1_V  = DIV_W'(DIV1);
  localparam logic [DIV_W-1:0] DIV2_V  = DIV_W'(DIV2);
  localparam logic [DIV_W-1:0] DIV3_V  = DIV_W'(DIV3);

  logic [DIV_W-1:0] m_q, m_d;
  logic [DIV_W-1:0] reload;
  logic             tick_w;

  ch_state_e        state_q [N_CH];
  ch_state_e        state_d [N_CH];
  logic [Y_W-1:0]   y_q     [N_CH];
  logic [Y_W-1:0]   y_d     [N_CH];
  logic [Y_W:0]     sum     [N_CH];

  // The rate code is only consulted at reload, so a mid-count change waits for the next tick.
  always_comb begin
    unique case (bus.rate)
      2'd0:    reload = DIV0_V;
      2'd1:    reload = DIV1_V;
      2'd2:    reload = DIV2_V;
      default: reload = DIV3_V;
    endcase
  end

  assign tick_w = bus.move_en && (m_q == '0);

  always_comb begin
    m_d = m_q;
    if (bus.move_en) begin
      m_d = (m_q == '0) ? reload : m_q - DIV_W'(1);
    end
  end

  // One extra bit keeps the sum from wrapping before it is clamped at Y_MAX.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      sum[i] = {1'b0, y_q[i]} + (Y_W+1)'(bus.step[2*i +: 2]) + (Y_W+1)'(1);
    end
  end

  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
      state_d[i] = state_q[i];
      y_d[i]     = y_q[i];
      if (bus.destroyed[i]) begin
        state_d[i] = ST_IDLE;
        y_d[i]     = '0;
      end else if (bus.spawn[i]) begin
        if (bus.spawn_y >= Y_MAX_V) begin
          state_d[i] = ST_EDGE;
          y_d[i]     = Y_MAX_V;
        end else begin
          state_d[i] = ST_FLY;
          y_d[i]     = bus.spawn_y;
        end
      end else if (state_q[i] == ST_FLY && tick_w && bus.ch_en[i]) begin
        if (sum[i] >= {1'b0, Y_MAX_V}) begin
          state_d[i] = ST_EDGE;
          y_d[i]     = Y_MAX_V;
        end else begin
          y_d[i]     = sum[i][Y_W-1:0];
        end
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      m_q <= reload;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= ST_IDLE;
        y_q[i]     <= '0;
      end
    end else begin
      m_q <= m_d;
      for (int i = 0; i < N_CH; i++) begin
        state_q[i] <= state_d[i];
        y_q[i]     <= y_d[i];
      end
    end
  end

  always_comb begin
    bus.y_flat     = '0;
    bus.active     = '0;
    bus.touch_edge = '0;
    for (int i = 0; i < N_CH; i++) begin
      bus.y_flat[i*Y_W +: Y_W] = y_q[i];
      bus.active[i]            = (state_q[i] == ST_FLY);
      bus.touch_edge[i]        = (state_q[i] == ST_EDGE);
    end
  end

  assign bus.tick = tick_w;

endmodule
